// File: rtl/tc_ram_arbiter_if.sv
// Requester-side bus of the TC RAM arbiter.
//
// Purpose: carries every requester's single-beat request and the per-requester
// grant and read-return pulses.
//
// Handshake: requester i raises req[i] together with we[i], addr[i] and
// wdata[i]. It holds all four stable until it samples gnt[i] high at a posedge.
// After that posedge it either drops req[i] or presents its next request.
// gnt[i] is a one-cycle pulse. For a read, rvalid[i] pulses for one cycle two
// cycles after the grant cycle, and rdata is meaningful only during that pulse.
//
// Signals:
//   req    [NUM_REQ]         per-requester request
//   we     [NUM_REQ]         1 = write, 0 = read
//   addr   [NUM_REQ*ADDR_W]  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   wdata  [NUM_REQ*DATA_W]  packed write data, same packing
//   gnt    [NUM_REQ]         one-hot one-cycle grant pulse
//   rvalid [NUM_REQ]         one-hot one-cycle read-data-valid pulse
//   rdata  [DATA_W]          registered read data
interface tc_ram_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        we;
    logic [NUM_REQ*ADDR_W-1:0] addr;
    logic [NUM_REQ*DATA_W-1:0] wdata;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        rvalid;
    logic [DATA_W-1:0]         rdata;

    // Requesters drive the request side and observe grant and return.
    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    // The arbiter observes requests and drives grant and return.
    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/tc_ram_arbiter.sv
// Round-robin arbiter and sequencer in front of the shared 256x8 single-port
// TC RAM (load/save/address/in/out interface).
//
// Purpose: grants one single-beat request per transaction and drives the RAM
// strobes from registers, so save stays stable across the RAM's negedge write.
// For a read, the data the RAM presents is returned to the owning requester.
//
// Ports:
//   clk          system clock, all logic on posedge
//   rst          synchronous reset, active-low
//   bus          requester bus (tc_ram_arbiter_if.slave)
//   busy         high whenever the FSM is not IDLE
//   ram_load     RAM load strobe (ISSUE cycle of a read only)
//   ram_save     RAM save strobe (ISSUE cycle of a write only)
//   ram_address  RAM address, holds its last value between transactions
//   ram_in       RAM write data, holds its last value between transactions
//   ram_out      RAM read data (valid the cycle after load was sampled)
//   state_dbg    current FSM state encoding (IDLE=0, ISSUE=1, WAIT=2)
//   ptr_dbg      round-robin pointer, zero-extended to 3 bits
//
// Timing, with T = posedge in IDLE where req is sampled:
//   gnt is high during T+1. A write lands at the negedge inside T+1 and the
//   next arbitration is at the posedge closing T+2. For a read, rvalid and
//   rdata are valid during T+3, and that cycle is already IDLE.
module tc_ram_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    tc_ram_arbiter_if.slave   bus,
    output logic              busy,
    output logic              ram_load,
    output logic              ram_save,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_in,
    input  logic [DATA_W-1:0] ram_out,
    output logic [1:0]        state_dbg,
    output logic [2:0]        ptr_dbg
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [IDX_W-1:0]   ptr, ptr_n;
    logic [IDX_W-1:0]   win, win_n;
    logic [NUM_REQ-1:0] grant, grant_n;
    logic [NUM_REQ-1:0] read_valid, read_valid_n;
    logic [DATA_W-1:0]  read_data, read_data_n;
    logic               load_n, save_n;
    logic [ADDR_W-1:0]  address_n;
    logic [DATA_W-1:0]  in_n;

    // Round-robin search result.
    logic               found;
    logic [IDX_W-1:0]   pick;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // First set request bit at or above ptr, wrapping modulo NUM_REQ.
    always_comb begin
        int cand;
        found = 1'b0;
        pick  = '0;
        cand  = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!found && bus.req[cand[IDX_W-1:0]]) begin
                found = 1'b1;
                pick  = cand[IDX_W-1:0];
            end
        end
    end

    // Next-state and next-output logic. Every strobe and data output is
    // registered, so all outputs are computed here one cycle ahead.
    always_comb begin
        state_n      = state;
        ptr_n        = ptr;
        win_n        = win;
        grant_n      = '0;
        read_valid_n = '0;
        read_data_n  = read_data;
        load_n       = ram_load;
        save_n       = ram_save;
        address_n    = ram_address;
        in_n         = ram_in;

        case (state)
            IDLE: begin
                if (found) begin
                    win_n     = pick;
                    ptr_n     = (pick == IDX_W'(NUM_REQ - 1)) ? '0 : pick + 1'b1;
                    grant_n   = onehot(pick);
                    address_n = bus.addr[pick*ADDR_W +: ADDR_W];
                    in_n      = bus.wdata[pick*DATA_W +: DATA_W];
                    save_n    = bus.we[pick];
                    load_n    = !bus.we[pick];
                    state_n   = ISSUE;
                end
            end

            ISSUE: begin
                // The write has already happened at this cycle's negedge. A
                // read's load is sampled by the RAM at the closing posedge.
                load_n  = 1'b0;
                save_n  = 1'b0;
                state_n = ram_save ? IDLE : WAIT;
            end

            WAIT: begin
                read_data_n  = ram_out;
                read_valid_n = onehot(win);
                state_n      = IDLE;
            end

            default: begin
                state_n = IDLE;
                load_n  = 1'b0;
                save_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            ptr         <= '0;
            win         <= '0;
            grant       <= '0;
            read_valid  <= '0;
            read_data   <= '0;
            ram_load    <= 1'b0;
            ram_save    <= 1'b0;
            ram_address <= '0;
            ram_in      <= '0;
        end else begin
            state       <= state_n;
            ptr         <= ptr_n;
            win         <= win_n;
            grant       <= grant_n;
            read_valid  <= read_valid_n;
            read_data   <= read_data_n;
            ram_load    <= load_n;
            ram_save    <= save_n;
            ram_address <= address_n;
            ram_in      <= in_n;
        end
    end

    assign bus.gnt    = grant;
    assign bus.rvalid = read_valid;
    assign bus.rdata  = read_data;
    assign busy       = (state != IDLE);
    assign state_dbg  = state;
    assign ptr_dbg    = 3'(ptr);

endmodule

// File: tb/tb_tc_ram_arbiter.sv
// Bench for tc_ram_arbiter: table of single-requester transactions plus
// hand-written sequences for round-robin order, pointer wrap, write-then-read
// ordering and reset during a read. A small 256x8 RAM model sits on the RAM
// port: write at negedge while save is high, read data registered when load is
// sampled at posedge and driven only in the following cycle.
module tb_tc_ram_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 8;

    logic              clk;
    logic              rst;
    logic              busy;
    logic              ram_load;
    logic              ram_save;
    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_in;
    logic [DATA_W-1:0] ram_out;
    logic [1:0]        state_dbg;
    logic [2:0]        ptr_dbg;

    tc_ram_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    tc_ram_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .busy        (busy),
        .ram_load    (ram_load),
        .ram_save    (ram_save),
        .ram_address (ram_address),
        .ram_in      (ram_in),
        .ram_out     (ram_out),
        .state_dbg   (state_dbg),
        .ptr_dbg     (ptr_dbg)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model
    logic [DATA_W-1:0] mem [256];
    logic [DATA_W-1:0] rd_q;
    logic              load_q;

    always @(negedge clk) begin
        if (ram_save) mem[ram_address] <= ram_in;
    end

    always @(posedge clk) begin
        load_q <= ram_load;
        if (ram_load) rd_q <= mem[ram_address];
    end

    assign ram_out = load_q ? rd_q : 'z;

    // Scoreboard counters
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // load and save must never be high together
    always @(negedge clk) begin
        if (rst) begin
            total++;
            if (ram_load && ram_save) begin
                bad++;
                $display("FAIL strobe_excl: got load=1 save=1 expected not both at %0t", $time);
            end
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input logic w, input logic [7:0] a, input logic [7:0] d);
        bus.req[id]            = 1'b1;
        bus.we[id]             = w;
        bus.addr[id*8 +: 8]    = a;
        bus.wdata[id*8 +: 8]   = d;
    endtask

    task automatic check_idle(input string name);
        check({name, "_gnt"},    32'(bus.gnt),    32'h0);
        check({name, "_rvalid"}, 32'(bus.rvalid), 32'h0);
        check({name, "_busy"},   32'(busy),       32'h0);
        check({name, "_load"},   32'(ram_load),   32'h0);
        check({name, "_save"},   32'(ram_save),   32'h0);
    endtask

    // One transaction from one requester with all others idle; called in an
    // IDLE cycle, returns in the first IDLE cycle after the transaction.
    task automatic run_single(input string name, input int id, input logic w,
                              input logic [7:0] a, input logic [7:0] d,
                              input logic [7:0] exp);
        logic [3:0] oh;
        oh = 4'b0001 << id;
        set_req(id, w, a, d);
        tick();
        check({name, "_gnt"},  32'(bus.gnt),     32'(oh));
        check({name, "_busy"}, 32'(busy),        32'h1);
        check({name, "_save"}, 32'(ram_save),    32'(w));
        check({name, "_load"}, 32'(ram_load),    32'(!w));
        check({name, "_addr"}, 32'(ram_address), 32'(a));
        if (w) check({name, "_in"}, 32'(ram_in), 32'(d));
        bus.req = '0;
        tick();
        if (w) begin
            check_idle({name, "_after"});
            check({name, "_mem"}, 32'(mem[a]), 32'(d));
        end else begin
            check({name, "_wait_state"}, 32'(state_dbg),  32'h2);
            check({name, "_wait_load"},  32'(ram_load),   32'h0);
            check({name, "_wait_rv"},    32'(bus.rvalid), 32'h0);
            tick();
            check({name, "_rvalid"}, 32'(bus.rvalid), 32'(oh));
            check({name, "_rdata"},  32'(bus.rdata),  32'(exp));
            check({name, "_busy2"},  32'(busy),       32'h0);
        end
    endtask

    typedef struct {
        int         id;
        logic       w;
        logic [7:0] a;
        logic [7:0] d;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [9];

    initial begin
        logic [3:0] oh;
        vecs[0] = '{id: 0, w: 1'b1, a: 8'h12, d: 8'hA5, exp: 8'h00};
        vecs[1] = '{id: 0, w: 1'b0, a: 8'h12, d: 8'h00, exp: 8'hA5};
        vecs[2] = '{id: 1, w: 1'b1, a: 8'h00, d: 8'h10, exp: 8'h00};
        vecs[3] = '{id: 2, w: 1'b1, a: 8'h01, d: 8'h11, exp: 8'h00};
        vecs[4] = '{id: 3, w: 1'b1, a: 8'h02, d: 8'h12, exp: 8'h00};
        vecs[5] = '{id: 0, w: 1'b1, a: 8'h03, d: 8'h13, exp: 8'h00};
        vecs[6] = '{id: 3, w: 1'b1, a: 8'hFF, d: 8'h5A, exp: 8'h00};
        vecs[7] = '{id: 3, w: 1'b0, a: 8'hFF, d: 8'h00, exp: 8'h5A};
        vecs[8] = '{id: 2, w: 1'b0, a: 8'h00, d: 8'h00, exp: 8'h10};

        rst       = 1'b0;
        bus.req   = '0;
        bus.we    = '0;
        bus.addr  = '0;
        bus.wdata = '0;

        // Reset then idle
        tick();
        tick();
        check_idle("reset");
        check("reset_rdata", 32'(bus.rdata),   32'h0);
        check("reset_addr",  32'(ram_address), 32'h0);
        check("reset_in",    32'(ram_in),      32'h0);
        check("reset_ptr",   32'(ptr_dbg),     32'h0);
        check("reset_state", 32'(state_dbg),   32'h0);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_idle($sformatf("idle%0d", i));
        end

        // Table-driven single transactions
        for (int i = 0; i < 9; i++) begin
            run_single($sformatf("vec%0d", i), vecs[i].id, vecs[i].w,
                       vecs[i].a, vecs[i].d, vecs[i].exp);
        end

        // Re-reset so round-robin starts from requester 0
        rst = 1'b0;
        tick();
        check("rr_reset_ptr", 32'(ptr_dbg), 32'h0);
        rst = 1'b1;
        tick();

        // Round-robin: all four read 0x00..0x03
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, 8'(i), 8'h00);
        for (int k = 0; k < 4; k++) begin
            oh = 4'b0001 << k;
            tick();
            check($sformatf("rr%0d_gnt", k), 32'(bus.gnt), 32'(oh));
            bus.req[k] = 1'b0;
            tick();
            tick();
            check($sformatf("rr%0d_rvalid", k), 32'(bus.rvalid), 32'(oh));
            check($sformatf("rr%0d_rdata", k),  32'(bus.rdata),  32'h10 + 32'(k));
        end

        // Pointer wrap: winner was 3, req3 and req1 together -> 1 then 3
        check("wrap_ptr", 32'(ptr_dbg), 32'h0);
        set_req(1, 1'b0, 8'h01, 8'h00);
        set_req(3, 1'b0, 8'h03, 8'h00);
        tick();
        check("wrap_gnt1", 32'(bus.gnt), 32'h2);
        bus.req[1] = 1'b0;
        tick();
        tick();
        check("wrap_rv1",   32'(bus.rvalid), 32'h2);
        check("wrap_rd1",   32'(bus.rdata),  32'h11);
        tick();
        check("wrap_gnt3", 32'(bus.gnt), 32'h8);
        bus.req[3] = 1'b0;
        tick();
        tick();
        check("wrap_rv3", 32'(bus.rvalid), 32'h8);
        check("wrap_rd3", 32'(bus.rdata),  32'h13);

        // Write-to-read ordering: req2 writes 0x7F, req3 reads 0x7F
        set_req(2, 1'b1, 8'h7F, 8'h3C);
        set_req(3, 1'b0, 8'h7F, 8'h00);
        tick();
        check("wr_gnt2",  32'(bus.gnt),  32'h4);
        check("wr_save2", 32'(ram_save), 32'h1);
        bus.req[2] = 1'b0;
        tick();
        check("wr_idle_busy", 32'(busy), 32'h0);
        tick();
        check("wr_gnt3",  32'(bus.gnt),  32'h8);
        check("wr_load3", 32'(ram_load), 32'h1);
        bus.req[3] = 1'b0;
        tick();
        tick();
        check("wr_rv3", 32'(bus.rvalid), 32'h8);
        check("wr_rd3", 32'(bus.rdata),  32'h3C);

        // Reset during WAIT drops the read
        set_req(1, 1'b0, 8'h01, 8'h00);
        tick();
        check("mid_gnt", 32'(bus.gnt), 32'h2);
        bus.req = '0;
        tick();
        check("mid_wait", 32'(state_dbg), 32'h2);
        rst = 1'b0;
        tick();
        check_idle("mid_rst");
        check("mid_state", 32'(state_dbg), 32'h0);
        check("mid_ptr",   32'(ptr_dbg),   32'h0);
        check("mid_rdata", 32'(bus.rdata), 32'h0);
        rst = 1'b1;
        tick();
        check("mid_norv", 32'(bus.rvalid), 32'h0);
        run_single("post_rst", 1, 1'b0, 8'h01, 8'h00, 8'h11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tc_ram_arbiter.md
Name: tc_ram_arbiter

Overview:
Round-robin arbiter and sequencer placed in front of the shared 256x8 single-port TC RAM (load/save/address/in/out interface). NUM_REQ requesters issue single-beat read or write requests. The arbiter grants one request per transaction, drives the RAM strobes with the correct phase, and returns read data to the owner. All RAM strobes come from registers, so save is stable across the RAM's negedge write.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 8, RAM address width
DATA_W, 8, RAM data width

Ports:
clk  in  1  system clock; all logic on posedge
rst  in  1  synchronous reset, active-low (0 = reset)
req  in  NUM_REQ  per-requester request; held with we/addr/wdata until gnt
we  in  NUM_REQ  per-requester: 1 = write, 0 = read
addr  in  NUM_REQ*ADDR_W  packed addresses; requester i at bits [i*ADDR_W +: ADDR_W]
wdata  in  NUM_REQ*DATA_W  packed write data, same packing
gnt  out  NUM_REQ  one-hot one-cycle grant pulse
rvalid  out  NUM_REQ  one-hot one-cycle read-data-valid pulse
rdata  out  DATA_W  registered read data; meaningful only while rvalid != 0
busy  out  1  high whenever state != IDLE
ram_load  out  1  to RAM load
ram_save  out  1  to RAM save
ram_address  out  ADDR_W  to RAM address
ram_in  out  DATA_W  to RAM in
ram_out  in  DATA_W  from RAM out; high-Z when RAM load was low

Behaviour:
- Reset (rst==0 at posedge) gives: state=IDLE; gnt, rvalid, ram_load, ram_save and busy = 0; rdata, ram_address and ram_in = 0; RR pointer = 0 (requester 0 highest priority).
- A reset mid-transaction drops it: no gnt or rvalid follows. A write is lost if reset lands before its ISSUE cycle.
- FSM states are IDLE, ISSUE and WAIT.
- IDLE: at each posedge with any req bit set, pick winner w:
  - w is the first set bit searching from ptr upward, wrapping modulo NUM_REQ.
  - Register ram_address=addr[w], ram_in=wdata[w], ram_save=we[w], ram_load=!we[w].
  - Set ptr=(w+1) mod NUM_REQ and go to ISSUE.
  - With no req, stay in IDLE; ptr is unchanged.
- ISSUE (one cycle): gnt[w]=1. The RAM write happens on this cycle's negedge; for a read the RAM samples load at the closing posedge.
  - Write: at that posedge clear ram_save and go to IDLE.
  - Read: clear ram_load and go to WAIT.
- WAIT (one cycle): ram_out holds mem[addr]. At the closing posedge capture rdata<=ram_out, set rvalid[w] for the next cycle, and go to IDLE.
- rvalid overlaps the next IDLE cycle, so arbitration can proceed during it.
- Latency, with T = posedge in IDLE where req is sampled:
  - gnt is high during cycle T+1.
  - Write: RAM updated at the negedge inside T+1; next arbitration at T+2.
  - Read: rvalid and rdata are valid during T+3; next arbitration at T+3.
- Throughput: 1 write per 2 cycles, 1 read per 3 cycles.
- Requester rule: keep req/we/addr/wdata stable from assertion until the posedge where gnt is sampled high. Then drop req or present the next request. A request held after gnt is treated as a new request.
- ram_load and ram_save are never high together. ram_load is high only in ISSUE of a read; ram_save only in ISSUE of a write. Outside transactions both are 0, and ram_address/ram_in hold their last values.
- rdata holds its value until the next read capture or reset.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,..,NUM_REQ-1,0. No requester waits more than NUM_REQ transactions.
- Simultaneous requests are resolved by RR order only; the read/write type has no priority.

Test Plan:
1. Reset then idle: hold rst=0 for 2 cycles, then rst=1 with req=0 for 5 cycles -> all outputs 0, busy=0, ram_load=ram_save=0 throughout.
2. Single write then read: req0 write addr 0x12 data 0xA5, then req0 read 0x12 -> gnt[0] at T+1 with ram_save=1, ram_address=0x12, ram_in=0xA5. Read: gnt at T+1, rvalid[0] at T+3, rdata=0xA5.
3. Round-robin: all 4 requesters hold read requests to addrs 0x00..0x03 (preloaded 0x10..0x13) -> gnt order 0,1,2,3, every 3 cycles; rdata 0x10,0x11,0x12,0x13 with matching rvalid bits.
4. Pointer wrap: after the winner is 3, assert req={1,0,1,0} (req3 and req1) -> requester 1 is granted first, then 3 (search starts at 0 and wraps).
5. Write-to-read ordering: req2 writes 0x7F=0x3C and req3 reads 0x7F in the same cycle -> req2 granted first; req3 rdata=0x3C.
6. Reset mid-read: drop rst during WAIT -> no rvalid, state IDLE, ptr=0. A following req1 read still returns correct data.
